// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 widths, access size and FSM states.
package riscv_mem_pkg;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    typedef enum logic [0:0] {
        MemStateIdle   = 1'b0,
        MemStateAccess = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } mem_size_e;

    // Low funct3 bits pick the width; 3'b011/3'b110/3'b111 fall through to word.
    function automatic mem_size_e mem_size(input logic [2:0] funct3);
        unique case (funct3[1:0])
            2'b00:   return SzByte;
            2'b01:   return SzHalf;
            default: return SzWord;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mem_align.sv
// Combinational lane logic: byte enables, store replication, load extraction, alignment check.
module riscv_mem_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_val_o,
    output logic        misalign_o
);

    logic [31:0] shifted;
    logic        is_unsigned;

    assign shifted     = rdata_i >> {addr_i, 3'b000};
    assign is_unsigned = funct3_i[2];

    // Decode size into lanes, replicated write data and extended read value.
    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = store_data_i;
        load_val_o = rdata_i;
        misalign_o = 1'b0;
        unique case (mem_size(funct3_i))
            SzByte: begin
                be_o       = 4'b0001 << addr_i;
                wdata_o    = {4{store_data_i[7:0]}};
                load_val_o = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SzHalf: begin
                be_o       = 4'b0011 << addr_i;
                wdata_o    = {2{store_data_i[15:0]}};
                load_val_o = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
                misalign_o = addr_i[0];
            end
            default: begin
                misalign_o = |addr_i;
            end
        endcase
    end

endmodule

// File: rtl/riscv_mem.sv
// Memory-access stage: issues one dmem transaction per load/store and produces a WB pulse.
module riscv_mem
    import riscv_mem_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGA = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [REGA-1:0] rdi,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      funct3,
    input  logic            load,
    input  logic            store,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [REGA-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned
);

    mem_state_e      state_q, state_d;
    logic            req_q, req_d, we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [REGA-1:0] rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic            is_load_q, is_load_d;
    logic            wb_valid_q, wb_valid_d, mis_q, mis_d;
    logic [REGA-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            idle;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata, al_load_val;
    logic            al_misalign;

    assign idle = (state_q == MemStateIdle);

    // Lane logic sees the incoming op in IDLE and the latched op while waiting for ack.
    assign al_funct3 = idle ? funct3 : funct3_q;
    assign al_addr   = idle ? result[1:0] : addr_lo_q;

    riscv_mem_align u_align (
        .funct3_i    (al_funct3),
        .addr_i      (al_addr),
        .store_data_i(store_data),
        .rdata_i     (dmem_rdata),
        .be_o        (al_be),
        .wdata_o     (al_wdata),
        .load_val_o  (al_load_val),
        .misalign_o  (al_misalign)
    );

    // Next-state logic for the IDLE/ACCESS FSM and the registered outputs.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        is_load_d  = is_load_q;
        wb_valid_d = 1'b0;
        mis_d      = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        unique case (state_q)
            MemStateIdle: begin
                if (in_valid) begin
                    if (!load && !store) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rdi;
                        wb_data_d  = result;
                    end else if (al_misalign) begin
                        wb_valid_d = 1'b1;
                        mis_d      = 1'b1;
                        wb_rd_d    = '0;
                        wb_data_d  = result;
                    end else begin
                        state_d   = MemStateAccess;
                        req_d     = 1'b1;
                        // load wins when both qualifiers are set
                        we_d      = ~load;
                        addr_d    = {result[XLEN-1:2], 2'b00};
                        be_d      = al_be;
                        wdata_d   = load ? '0 : al_wdata;
                        rd_d      = rdi;
                        funct3_d  = funct3;
                        addr_lo_d = result[1:0];
                        is_load_d = load;
                    end
                end
            end
            MemStateAccess: begin
                if (dmem_ack) begin
                    state_d    = MemStateIdle;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = is_load_q ? rd_q : '0;
                    wb_data_d  = is_load_q ? al_load_val : '0;
                end
            end
            default: state_d = MemStateIdle;
        endcase
    end

    // State and output registers; async reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MemStateIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            is_load_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            is_load_q  <= is_load_d;
            wb_valid_q <= wb_valid_d;
            mis_q      <= mis_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign in_ready   = idle & ~rst;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_riscv_mem.sv
// Directed bench for riscv_mem: inputs change and outputs are sampled on the falling edge.
module tb_riscv_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  rdi;
    logic [31:0] result, store_data;
    logic [2:0]  funct3;
    logic        load, store;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_mem dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rdi       (rdi),
        .result    (result),
        .store_data(store_data),
        .funct3    (funct3),
        .load      (load),
        .store     (store),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be   (dmem_be),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .misaligned(misaligned)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one op for a single cycle; returns on the falling edge after capture.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd);
        in_valid   = 1'b1;
        load       = ld;
        store      = st;
        funct3     = f3;
        result     = res;
        store_data = sd;
        rdi        = rd;
        @(negedge clk);
        in_valid = 1'b0;
        load     = 1'b0;
        store    = 1'b0;
    endtask

    // Ack the outstanding request after `waits` idle request cycles, then check the WB pulse.
    task automatic complete(input int waits, input logic [31:0] rdata, input string tag,
                            input logic [4:0] exp_rd, input logic [31:0] exp_data);
        for (int i = 0; i <= waits; i++) begin
            check_eq({tag, "_wait_req"}, {31'd0, dmem_req}, 32'd1);
            check_eq({tag, "_wait_ready"}, {31'd0, in_ready}, 32'd0);
            if (i == waits) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        check_eq({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
        check_eq({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, exp_rd});
        check_eq({tag, "_wb_data"}, wb_data, exp_data);
        check_eq({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
        check_eq({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
        check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check_eq({tag, "_wb_pulse"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        rdi        = 5'd0;
        result     = 32'h0;
        store_data = 32'h0;
        funct3     = 3'b000;
        load       = 1'b0;
        store      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);

        // ALU passthrough
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        check_eq("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
        check_eq("alu_wb_data", wb_data, 32'h0000_1234);
        check_eq("alu_no_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        check_eq("alu_pulse", {31'd0, wb_valid}, 32'd0);
        check_eq("alu_hold_data", wb_data, 32'h0000_1234);
        check_eq("alu_no_req2", {31'd0, dmem_req}, 32'd0);

        // LB sign-extend, three wait cycles
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        check_eq("lb_addr", dmem_addr, 32'h0000_0100);
        check_eq("lb_be", {28'd0, dmem_be}, 32'h8);
        check_eq("lb_we", {31'd0, dmem_we}, 32'd0);
        complete(3, 32'h80FF_FFFF, "lb", 5'd7, 32'hFFFF_FF80);

        // LHU zero-extend, immediate ack
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 5'd9);
        check_eq("lhu_addr", dmem_addr, 32'h0000_0200);
        check_eq("lhu_be", {28'd0, dmem_be}, 32'hC);
        complete(0, 32'hBEEF_0000, "lhu", 5'd9, 32'h0000_BEEF);

        // SB
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AA, 5'd4);
        check_eq("sb_we", {31'd0, dmem_we}, 32'd1);
        check_eq("sb_addr", dmem_addr, 32'h0000_0300);
        check_eq("sb_be", {28'd0, dmem_be}, 32'h2);
        check_eq("sb_wdata", dmem_wdata, 32'hAAAA_AAAA);
        complete(1, 32'h0, "sb", 5'd0, 32'h0);

        // SH upper half
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0306, 32'h1234_ABCD, 5'd4);
        check_eq("sh_be", {28'd0, dmem_be}, 32'hC);
        check_eq("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        complete(0, 32'h0, "sh", 5'd0, 32'h0);

        // LH sign-extend from upper half
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'h0, 5'd3);
        check_eq("lh_be", {28'd0, dmem_be}, 32'hC);
        complete(0, 32'h9ABC_0000, "lh", 5'd3, 32'hFFFF_9ABC);

        // Undefined funct3 3'b011 acts as a word load
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0600, 32'h0, 5'd11);
        check_eq("lw_undef_be", {28'd0, dmem_be}, 32'hF);
        complete(0, 32'hDEAD_BEEF, "lw_undef", 5'd11, 32'hDEAD_BEEF);

        // Misaligned LW
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0402, 32'h0, 5'd8);
        check_eq("mis_lw_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("mis_lw_flag", {31'd0, misaligned}, 32'd1);
        check_eq("mis_lw_rd", {27'd0, wb_rd}, 32'd0);
        check_eq("mis_lw_data", wb_data, 32'h0000_0402);
        check_eq("mis_lw_no_req", {31'd0, dmem_req}, 32'd0);
        check_eq("mis_lw_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check_eq("mis_lw_pulse", {31'd0, misaligned}, 32'd0);
        check_eq("mis_lw_no_req2", {31'd0, dmem_req}, 32'd0);

        // Misaligned SH
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0501, 32'h5555_5555, 5'd2);
        check_eq("mis_sh_flag", {31'd0, misaligned}, 32'd1);
        check_eq("mis_sh_data", wb_data, 32'h0000_0501);
        check_eq("mis_sh_no_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);

        // Reset while waiting for ack
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd6);
        check_eq("rstacc_req_before", {31'd0, dmem_req}, 32'd1);
        #1 rst = 1'b1;
        #1 check_eq("rstacc_req_async", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rstacc_no_wb", {31'd0, wb_valid}, 32'd0);
            check_eq("rstacc_no_req", {31'd0, dmem_req}, 32'd0);
        end
        check_eq("rstacc_ready", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
